// File: rtl/dcm_pkg.sv
// dcm_pkg: shared widths and the clk_2 half-period lookup for the clock manager
package dcm_pkg;
    localparam int PROG_W = 3;
    localparam int CNT_W  = 8;

    function automatic logic [CNT_W:0] half_period(input logic [PROG_W-1:0] code);
        return (CNT_W + 1)'(1) << ({1'b0, code} + 4'd1);
    endfunction
endpackage

// File: rtl/dcm_divider.sv
// dcm_divider: half-period counter plus toggle flop; DCM_GLITCHFREE_EN exposes the wrap strobe
module dcm_divider
    import dcm_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           restart,
    input  logic [CNT_W:0] half,
    output logic           clk_out
`ifdef DCM_GLITCHFREE_EN
    ,
    output logic           wrap
`endif
);
`ifndef DCM_GLITCHFREE_EN
    logic wrap;
`endif
    logic [CNT_W-1:0] cnt;

    assign wrap = {1'b0, cnt} == half - 1'b1;

    // count to half-1, then toggle and wrap; restart forces a fresh low phase
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cnt     <= '0;
            clk_out <= 1'b0;
        end else if (restart) begin
            cnt     <= '0;
            clk_out <= 1'b0;
        end else if (wrap) begin
            cnt     <= '0;
            clk_out <= ~clk_out;
        end else begin
            cnt <= cnt + 1'b1;
        end
endmodule

// File: rtl/dcm.sv
// dcm: clk/2 output plus programmable clk/2^(code+2) output; DCM_GLITCHFREE_EN defers code changes to a clk_2 fall
module dcm
    import dcm_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [PROG_W-1:0] prog_in,
    input  logic              update,
    output logic              clk_1,
    output logic              clk_2,
    output logic [PROG_W-1:0] prog_out
);
    logic update_q;
    logic load;
    logic restart;

    assign load = update & ~update_q;

    // fixed divide-by-2 and the update edge detector
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            clk_1    <= 1'b0;
            update_q <= 1'b0;
        end else begin
            clk_1    <= ~clk_1;
            update_q <= update;
        end

`ifdef DCM_GLITCHFREE_EN
    logic              wrap;
    logic              apply;
    logic              pend;
    logic [PROG_W-1:0] pending;

    assign restart = 1'b0;
    assign apply   = pend & wrap & clk_2;

    // park the requested code and apply it only where clk_2 falls naturally
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            prog_out <= '0;
            pending  <= '0;
            pend     <= 1'b0;
        end else begin
            if (load)
                pending <= prog_in;
            if (apply)
                prog_out <= load ? prog_in : pending;
            pend <= (load | pend) & ~apply;
        end

    dcm_divider u_div2 (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .half    (half_period(prog_out)),
        .clk_out (clk_2),
        .wrap    (wrap)
    );
`else
    assign restart = load;

    // take the new code at once; the divider restarts its phase on the same edge
    always_ff @(posedge clk or posedge rst)
        if (rst)
            prog_out <= '0;
        else if (load)
            prog_out <= prog_in;

    dcm_divider u_div2 (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .half    (half_period(prog_out)),
        .clk_out (clk_2)
    );
`endif
endmodule

// File: tb/tb_dcm.sv
// tb_dcm: scoreboard bench for dcm, measuring clk_2 low/high phase lengths in clk cycles
module tb_dcm;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] prog_in = 3'd0;
    logic       update = 1'b0;
    logic       clk_1;
    logic       clk_2;
    logic [2:0] prog_out;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        int         lo;
        int         hi;
        logic [2:0] code;
    } exp_t;
    exp_t sb[$];
    exp_t e;
    int   lo, hi;

    dcm dut (
        .clk      (clk),
        .rst      (rst),
        .prog_in  (prog_in),
        .update   (update),
        .clk_1    (clk_1),
        .clk_2    (clk_2),
        .prog_out (prog_out)
    );

    always #5 clk = ~clk;

    function automatic int hp(input int code);
        return 1 << (code + 1);
    endfunction

    task automatic measure(output int l, output int h);
        l = 0;
        h = 0;
        while (clk_2 === 1'b0 && l < 1000) begin
            l++;
            @(negedge clk);
        end
        while (clk_2 === 1'b1 && h < 1000) begin
            h++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        update = 1'b1;
        repeat (2) @(negedge clk);
        update = 1'b0;
        repeat (7) @(negedge clk);
        compared++;
        if (clk_1 !== 1'b0 || clk_2 !== 1'b0 || prog_out !== 3'd0) begin
            mismatched++;
            $display("FAIL reset_state clk_1=%b clk_2=%b prog_out=%0d expected 0/0/0", clk_1, clk_2, prog_out);
        end
        sb.push_back('{lo: hp(0), hi: hp(0), code: 3'd0});
        rst = 1'b0;
        measure(lo, hi);
        e = sb.pop_front();
        compared++;
        if (lo !== e.lo || hi !== e.hi || prog_out !== e.code) begin
            mismatched++;
            $display("FAIL reset_clk2 lo=%0d hi=%0d code=%0d expected %0d/%0d/%0d", lo, hi, prog_out, e.lo, e.hi, e.code);
        end
        for (int i = 0; i < 4; i++) begin
            logic prev;
            prev = clk_1;
            @(negedge clk);
            compared++;
            if (clk_1 !== ~prev) begin
                mismatched++;
                $display("FAIL clk_1_toggle step %0d got %b expected %b", i, clk_1, ~prev);
            end
        end
    endtask

    task automatic test_load();
        prog_in = 3'd3;
        update = 1'b1;
        sb.push_back('{lo: hp(3), hi: hp(3), code: 3'd3});
        @(negedge clk);
        compared++;
        if (prog_out !== 3'd3 || clk_2 !== 1'b0) begin
            mismatched++;
            $display("FAIL load3_first_edge prog_out=%0d clk_2=%b expected 3/0", prog_out, clk_2);
        end
        fork
            begin
                repeat (4) @(negedge clk);
                update = 1'b0;
            end
            measure(lo, hi);
        join
        e = sb.pop_front();
        compared++;
        if (lo !== e.lo || hi !== e.hi || prog_out !== e.code) begin
            mismatched++;
            $display("FAIL load3_phases lo=%0d hi=%0d code=%0d expected %0d/%0d/%0d", lo, hi, prog_out, e.lo, e.hi, e.code);
        end
    endtask

    task automatic test_sweep();
        for (int c = 0; c < 8; c++) begin
            prog_in = 3'(c);
            update = 1'b1;
            sb.push_back('{lo: hp(c), hi: hp(c), code: 3'(c)});
            @(negedge clk);
            update = 1'b0;
            measure(lo, hi);
            e = sb.pop_front();
            compared++;
            if (lo !== e.lo || hi !== e.hi || prog_out !== e.code) begin
                mismatched++;
                $display("FAIL sweep_code%0d lo=%0d hi=%0d code=%0d expected %0d/%0d/%0d", c, lo, hi, prog_out, e.lo, e.hi, e.code);
            end
        end
    endtask

    task automatic test_same_code();
        int n;
        prog_in = 3'd1;
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
        n = 0;
        while (clk_2 !== 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
        compared++;
        if (clk_2 !== 1'b0 || prog_out !== 3'd1) begin
            mismatched++;
            $display("FAIL same_code_restart1 clk_2=%b prog_out=%0d expected 0/1", clk_2, prog_out);
        end
        repeat (4) @(negedge clk);
        compared++;
        if (clk_2 !== 1'b1) begin
            mismatched++;
            $display("FAIL same_code_rise clk_2=%b expected 1", clk_2);
        end
        update = 1'b1;
        sb.push_back('{lo: hp(1), hi: hp(1), code: 3'd1});
        @(negedge clk);
        update = 1'b0;
        compared++;
        if (clk_2 !== 1'b0 || prog_out !== 3'd1) begin
            mismatched++;
            $display("FAIL same_code_restart2 clk_2=%b prog_out=%0d expected 0/1", clk_2, prog_out);
        end
        measure(lo, hi);
        e = sb.pop_front();
        compared++;
        if (lo !== e.lo || hi !== e.hi || prog_out !== e.code) begin
            mismatched++;
            $display("FAIL same_code_phases lo=%0d hi=%0d code=%0d expected %0d/%0d/%0d", lo, hi, prog_out, e.lo, e.hi, e.code);
        end
    endtask

    task automatic test_hold();
        prog_in = 3'd2;
        update = 1'b1;
        sb.push_back('{lo: hp(2), hi: hp(2), code: 3'd2});
        @(negedge clk);
        fork
            begin
                repeat (4) @(negedge clk);
                update = 1'b0;
            end
            measure(lo, hi);
        join
        e = sb.pop_front();
        compared++;
        if (lo !== e.lo || hi !== e.hi || prog_out !== e.code) begin
            mismatched++;
            $display("FAIL hold_single_load lo=%0d hi=%0d code=%0d expected %0d/%0d/%0d", lo, hi, prog_out, e.lo, e.hi, e.code);
        end
    endtask

    task automatic test_reset_mid();
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        compared++;
        if (clk_1 !== 1'b0 || clk_2 !== 1'b0 || prog_out !== 3'd0) begin
            mismatched++;
            $display("FAIL reset_mid clk_1=%b clk_2=%b prog_out=%0d expected 0/0/0", clk_1, clk_2, prog_out);
        end
        prog_in = 3'd5;
        update = 1'b1;
        repeat (2) @(negedge clk);
        compared++;
        if (prog_out !== 3'd0) begin
            mismatched++;
            $display("FAIL reset_ignores_update prog_out=%0d expected 0", prog_out);
        end
        rst = 1'b0;
        sb.push_back('{lo: hp(5), hi: hp(5), code: 3'd5});
        @(negedge clk);
        compared++;
        if (prog_out !== 3'd5) begin
            mismatched++;
            $display("FAIL release_with_update prog_out=%0d expected 5", prog_out);
        end
        fork
            begin
                @(negedge clk);
                update = 1'b0;
            end
            measure(lo, hi);
        join
        e = sb.pop_front();
        compared++;
        if (lo !== e.lo || hi !== e.hi || prog_out !== e.code) begin
            mismatched++;
            $display("FAIL release_phases lo=%0d hi=%0d code=%0d expected %0d/%0d/%0d", lo, hi, prog_out, e.lo, e.hi, e.code);
        end
    endtask

    task automatic test_glitchfree();
        int   n;
        int   run;
        logic prev;
        n = 0;
        while (clk_2 !== 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        prog_in = 3'd7;
        update = 1'b1;
        sb.push_back('{lo: hp(7), hi: hp(7), code: 3'd7});
        run = 1;
        @(negedge clk);
        update = 1'b0;
        compared++;
        if (prog_out !== 3'd0) begin
            mismatched++;
            $display("FAIL gf_deferred prog_out=%0d expected 0", prog_out);
        end
        prev = 1'b1;
        n = 0;
        while (prog_out !== 3'd7 && n < 20) begin
            if (clk_2 === 1'b1)
                run++;
            prev = clk_2;
            n++;
            @(negedge clk);
        end
        compared++;
        if (prev !== 1'b1 || clk_2 !== 1'b0 || run !== hp(0)) begin
            mismatched++;
            $display("FAIL gf_apply_at_fall prev=%b clk_2=%b high_run=%0d expected 1/0/%0d", prev, clk_2, run, hp(0));
        end
        measure(lo, hi);
        e = sb.pop_front();
        compared++;
        if (lo !== e.lo || hi !== e.hi || prog_out !== e.code) begin
            mismatched++;
            $display("FAIL gf_phases lo=%0d hi=%0d code=%0d expected %0d/%0d/%0d", lo, hi, prog_out, e.lo, e.hi, e.code);
        end
    endtask

    initial begin
        test_reset();
`ifdef DCM_GLITCHFREE_EN
        test_glitchfree();
`else
        test_load();
        test_sweep();
        test_same_code();
        test_hold();
        test_reset_mid();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
